// File: rtl/seg_scan_ctrl_pkg.sv
// Shared seven-segment defines: segment codes, digit count and scan states.
// Codes are active-low with bit7 as the decimal point (kept off here).
package seg_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NIB_W      = 4;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] AN_OFF    = 4'b1111;
    localparam logic [3:0] NIB_BLANK = 4'hF;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_led_decode.sv
// Team nibble-to-segment decoder; non-decimal nibbles render blank.
module led_decode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed LED scan controller with blanking, leading-zero
// suppression and frame-aligned double-buffered display updates.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic        lz_en,
    input  logic [3:0]  dp_mask,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        upd,
    output logic        overrun
);

    localparam int CW    = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0]    CNT_MAX   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]    BLANK_END = CW'(BLANK_CYC);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      disp_q, disp_d;
    logic [15:0]      pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             upd_q, upd_d;
    logic             overrun_q, overrun_d;

    logic             slot_end;
    logic             frame_end;
    scan_state_t      state;
    logic [3:0]       cur_nib;
    logic             upper_zero;
    logic             suppress;
    logic [3:0]       dec_nib;
    logic [7:0]       dec_seg;

    assign slot_end  = (cnt_q == CNT_MAX);
    assign frame_end = slot_end && (idx_q == LAST_IDX);
    assign state     = (cnt_q < BLANK_END) ? ST_BLANK : ST_DRIVE;

    // Nibble idx and everything above it being zero means a leading zero.
    assign cur_nib    = disp_q[{idx_q, 2'b00} +: NIB_W];
    assign upper_zero = ((disp_q >> {idx_q, 2'b00}) == 16'h0000);
    assign suppress   = lz_en && (idx_q != '0) && upper_zero;
    assign dec_nib    = suppress ? NIB_BLANK : cur_nib;

    led_decode u_dec (
        .nib (dec_nib),
        .seg (dec_seg)
    );

    always_comb begin
        cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
        idx_d        = idx_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        seg_d        = SEG_BLANK;
        an_d         = AN_OFF;
        upd_d        = 1'b0;
        overrun_d    = 1'b0;

        if (slot_end) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end

        case (state)
            ST_DRIVE: begin
                an_d  = ~(4'b0001 << idx_q);
                seg_d = dec_seg & ~{dp_mask[idx_q], 7'b000_0000};
            end
            default: begin
                an_d  = AN_OFF;
                seg_d = SEG_BLANK;
            end
        endcase

        // Display only swaps on a frame boundary; a coincident load refills pend.
        if (frame_end && pend_valid_q) begin
            disp_d       = pend_q;
            pend_valid_d = 1'b0;
            upd_d        = 1'b1;
        end

        if (load) begin
            pend_d       = data_in;
            pend_valid_d = 1'b1;
            overrun_d    = pend_valid_q && !frame_end;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= 16'h0000;
            pend_q       <= 16'h0000;
            pend_valid_q <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= AN_OFF;
            upd_q        <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            upd_q        <= upd_d;
            overrun_q    <= overrun_d;
        end
    end

    assign seg     = seg_q;
    assign an      = an_q;
    assign upd     = upd_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed and random bench for seg_scan_ctrl with a cycle-count reference model.
module tb_seg_scan_ctrl;

    localparam int CLK_DIV   = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = CLK_DIV * 4;

    localparam logic [7:0] CODES [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic        lz_en = 1'b0;
    logic [3:0]  dp_mask = 4'h0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        upd;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    int          m_t = 0;
    logic [15:0] m_disp = 16'h0;
    logic [15:0] m_pend = 16'h0;
    logic        m_pv = 1'b0;
    logic [7:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_upd;
    logic        e_ovr;
    int          n_upd = 0;
    int          n_ovr = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .data_in (data_in),
        .lz_en   (lz_en),
        .dp_mask (dp_mask),
        .seg     (seg),
        .an      (an),
        .upd     (upd),
        .overrun (overrun)
    );

    function automatic logic [7:0] ref_seg(logic [15:0] disp, int d,
                                           logic lz, logic [3:0] dp);
        int nib = int'((disp >> (4 * d)) & 16'h000F);
        logic [7:0] s = (nib < 10) ? CODES[nib] : 8'hFF;
        if (lz && d > 0 && (disp >> (4 * d)) == 16'h0000) s = 8'hFF;
        if (dp[d]) s[7] = 1'b0;
        return s;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        int c;
        int d;
        logic fe;
        @(posedge clk);
        if (rst) begin
            e_an   = 4'hF;
            e_seg  = 8'hFF;
            e_upd  = 1'b0;
            e_ovr  = 1'b0;
            m_t    = 0;
            m_disp = 16'h0;
            m_pend = 16'h0;
            m_pv   = 1'b0;
        end else begin
            c  = m_t % CLK_DIV;
            d  = (m_t / CLK_DIV) % 4;
            fe = (c == CLK_DIV - 1) && (d == 3);
            if (c < BLANK_CYC) begin
                e_an  = 4'hF;
                e_seg = 8'hFF;
            end else begin
                e_an  = 4'hF ^ (4'b0001 << d);
                e_seg = ref_seg(m_disp, d, lz_en, dp_mask);
            end
            e_upd = fe && m_pv;
            e_ovr = load && m_pv && !fe;
            if (fe && m_pv) begin
                m_disp = m_pend;
                m_pv   = 1'b0;
            end
            if (load) begin
                m_pend = data_in;
                m_pv   = 1'b1;
            end
            m_t++;
        end
        #1;
        chk("seg", 32'(seg), 32'(e_seg));
        chk("an", 32'(an), 32'(e_an));
        chk("upd", 32'(upd), 32'(e_upd));
        chk("overrun", 32'(overrun), 32'(e_ovr));
        if (upd === 1'b1) n_upd++;
        if (overrun === 1'b1) n_ovr++;
        @(negedge clk);
    endtask

    task automatic steps(int n);
        repeat (n) step();
    endtask

    task automatic wait_frame();
        while (m_t % FRAME != 0) step();
    endtask

    task automatic pulse_load(logic [15:0] v);
        data_in = v;
        load    = 1'b1;
        step();
        load    = 1'b0;
    endtask

    task automatic show(logic [15:0] v);
        wait_frame();
        pulse_load(v);
        steps(FRAME - 1);
    endtask

    task automatic check_frame(logic [7:0] e0, logic [7:0] e1,
                               logic [7:0] e2, logic [7:0] e3);
        logic [7:0] e [4];
        int c;
        int d;
        e[0] = e0;
        e[1] = e1;
        e[2] = e2;
        e[3] = e3;
        wait_frame();
        for (int k = 0; k < FRAME; k++) begin
            step();
            c = k % CLK_DIV;
            d = k / CLK_DIV;
            if (c < BLANK_CYC) begin
                chk("frame_seg", 32'(seg), 32'h0000_00FF);
                chk("frame_an", 32'(an), 32'h0000_000F);
            end else begin
                chk("frame_seg", 32'(seg), 32'(e[d]));
                chk("frame_an", 32'(an), 32'(4'hF ^ (4'b0001 << d)));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        rst     = 1'b1;
        load    = 1'b1;
        data_in = 16'hBEEF;
        steps(3);
        load = 1'b0;
        rst  = 1'b0;

        n_upd = 0;
        check_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0);
        check_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0);
        chk("scan_upd", 32'(n_upd), 32'd0);

        wait_frame();
        n_upd = 0;
        steps(5);
        pulse_load(16'h1234);
        steps(FRAME - 6);
        chk("defer_upd", 32'(n_upd), 32'd1);
        n_upd = 0;
        check_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
        chk("defer_upd_after", 32'(n_upd), 32'd0);

        lz_en = 1'b1;
        show(16'h0050);
        check_frame(8'hC0, 8'h92, 8'hFF, 8'hFF);
        show(16'h0000);
        check_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF);
        lz_en = 1'b0;

        wait_frame();
        n_ovr = 0;
        pulse_load(16'h1111);
        steps(2);
        pulse_load(16'h2222);
        steps(FRAME - 4);
        chk("ovr_count", 32'(n_ovr), 32'd1);
        check_frame(8'hA4, 8'hA4, 8'hA4, 8'hA4);

        wait_frame();
        n_ovr = 0;
        pulse_load(16'h3333);
        steps(FRAME - 2);
        pulse_load(16'h4444);
        chk("fe_load_ovr", 32'(n_ovr), 32'd0);
        check_frame(8'hB0, 8'hB0, 8'hB0, 8'hB0);
        check_frame(8'h99, 8'h99, 8'h99, 8'h99);

        dp_mask = 4'b0001;
        show(16'h00A0);
        check_frame(8'h40, 8'hFF, 8'hC0, 8'hC0);
        dp_mask = 4'b0010;
        check_frame(8'hC0, 8'h7F, 8'hC0, 8'hC0);
        dp_mask = 4'b0000;

        wait_frame();
        n_upd = 0;
        pulse_load(16'h5555);
        steps(2 * CLK_DIV + 4 - 1);
        rst = 1'b1;
        step();
        chk("rst_an", 32'(an), 32'h0000_000F);
        chk("rst_seg", 32'(seg), 32'h0000_00FF);
        rst = 1'b0;
        check_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0);
        chk("rst_upd", 32'(n_upd), 32'd0);

        repeat (800) begin
            load    = ($urandom_range(9) == 0);
            data_in = 16'($urandom) >> (4 * $urandom_range(4));
            lz_en   = 1'($urandom_range(1));
            if ($urandom_range(15) == 0) dp_mask = 4'($urandom);
            rst     = ($urandom_range(299) == 0);
            step();
        end
        rst  = 1'b0;
        load = 1'b0;
        steps(FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, meaning clock cycles per digit slot (legal range 4..2^20).
REQ-002 SHALL have parameter BLANK_CYC, default 500, meaning anti-ghost blank cycles at the start of each slot (legal range 1..CLK_DIV-2).
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port load  input  1  one-cycle strobe that captures data_in.
REQ-006 SHALL have port data_in  input  16  four digit nibbles, where [3:0] is digit0 (rightmost) and [15:12] is digit3.
REQ-007 SHALL have port lz_en  input  1  leading-zero suppression enable, sampled every cycle.
REQ-008 SHALL have port dp_mask  input  4  per-digit decimal-point enable, where bit i is digit i.
REQ-009 SHALL have port seg  output  8  active-low segment pattern; bit7 is the decimal point.
REQ-010 SHALL have port an  output  4  active-low digit enable, where bit i is digit i.
REQ-011 SHALL have port upd  output  1  one-cycle pulse when the display register takes new data.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse when a load overwrites an undisplayed pending value.

Function
REQ-013 Slot counter cnt SHALL count 0..CLK_DIV-1 and wrap to 0; slot_end is defined as cnt==CLK_DIV-1.
REQ-014 Digit index idx SHALL increment on slot_end and wrap from 3 to 0; frame_end is defined as slot_end && idx==3.
REQ-015 State SHALL be BLANK while cnt<BLANK_CYC and DRIVE otherwise; no other states exist.
REQ-016 In BLANK, the next-cycle outputs SHALL be an=4'b1111 and seg=8'hFF.
REQ-017 In DRIVE, the next-cycle outputs SHALL be an with only bit idx low, and seg equal to the decoded nibble disp[idx].
REQ-018 seg and an SHALL be registered, lagging the cnt/idx state by exactly 1 cycle.
REQ-019 Decoding SHALL be: 0..9 map to the team segment codes (0=8'hC0, 1=8'hF9, 2=8'hA4, 3=8'hB0, 4=8'h99, 5=8'h92, 6=8'h82, 7=8'hF8, 8=8'h80, 9=8'h90); nibbles A..F map to 8'hFF.
REQ-020 With lz_en=1, digit i (i=1..3) SHALL be blanked (seg=8'hFF) when disp nibbles i..3 are all zero; digit0 is never suppressed.
REQ-021 When dp_mask[idx]=1 in DRIVE, seg[7] SHALL be 0, including on digits blanked by REQ-019 or REQ-020.
REQ-022 On load, data_in SHALL be written to register pend and pend_valid set to 1.
REQ-023 On frame_end with pend_valid=1, disp SHALL take pend, pend_valid SHALL clear, and upd SHALL pulse on the next cycle.
REQ-024 On frame_end with pend_valid=0, disp SHALL be unchanged and upd SHALL stay 0.
REQ-025 When load coincides with frame_end, disp SHALL take the old pend (if pend_valid=1); the new data SHALL go to pend with pend_valid=1; overrun SHALL NOT pulse.
REQ-026 When load occurs with pend_valid=1 and not at frame_end, pend SHALL be overwritten (latest wins) and overrun SHALL pulse on the next cycle.
REQ-027 disp SHALL never change except at frame_end, so no displayed frame mixes two loads.

Reset
REQ-028 While rst=1, the block SHALL force cnt=0, idx=0, disp=16'h0000, pend=16'h0000, pend_valid=0, an=4'b1111, seg=8'hFF, upd=0 and overrun=0.
REQ-029 Reset SHALL take priority over a simultaneous load.
REQ-030 Reset asserted mid-slot SHALL discard any pending load.
REQ-031 After rst deasserts, the first slot SHALL begin in BLANK for digit0.

Structure
REQ-032 The segment codes, SEG_BLANK=8'hFF, the digit count (4) and the BLANK/DRIVE state encoding SHALL live in the shared seg defines package.
REQ-033 Nibble-to-segment decoding SHALL instantiate the team decoder led_decode as the single sub-module.
REQ-034 Digit suppression SHALL be implemented by feeding 4'hF to led_decode.
REQ-035 The decimal point SHALL be applied after led_decode.

Verification (CLK_DIV=8, BLANK_CYC=2)
REQ-036 Scenario reset-scan: release rst with no load and lz_en=0 -> an repeats the sequence 1111 x2, 1110 x6, 1111 x2, 1101 x6, 1111 x2, 1011 x6, 1111 x2, 0111 x6; seg=8'hC0 in every DRIVE slot.
REQ-037 Scenario deferred load: load 16'h1234 at cycle 5 of a frame -> disp is unchanged for the rest of that frame; upd pulses once 1 cycle after frame_end; the next frame shows digit0=8'h99, digit1=8'hB0, digit2=8'hA4, digit3=8'hF9.
REQ-038 Scenario leading zeros: lz_en=1 with 16'h0050 -> digit3=8'hFF, digit2=8'hFF, digit1=8'h92, digit0=8'hC0; with 16'h0000 -> only digit0 shows 8'hC0.
REQ-039 Scenario overrun: load 16'h1111, then load 16'h2222 three cycles later within the same frame -> overrun pulses once, and the next frame displays 2222 (8'hA4 on all digits).
REQ-040 Scenario boundary cases: load coincident with frame_end -> no overrun, and the value appears one frame later; nibble A displays 8'hFF; dp_mask=4'b0001 with digit0=0 -> 8'h40.
REQ-041 Scenario mid-slot reset: assert rst at cnt=4 of digit2 with pend_valid=1 -> the next cycle shows an=4'b1111 and seg=8'hFF; afterwards digit0 shows 8'hC0 and no upd pulse occurs.
